task_issuer: RTL and testbench
==============================

# task_issuer

Initiator side of the accelerator task-control handshake. Accepts a stream of task commands (recv / send / conv / recv+conv) from the layer scheduler, issues each one to the task-control responder as a single-cycle `task_valid` pulse with matching enable pulses, waits for the responder's `ap_done`, and only then issues the next. Sits between the layer scheduler and the control-signal generator; adds illegal-code filtering, a completion timeout and batch-end reporting.

## Interface
Parameters:
- `GUARD_CYC`, 3, cycles after `task_valid` during which `ap_done` is ignored (covers responder's stale-done latency); legal 2..15
- `TIMEOUT_CYC`, 1048576, max cycles waiting for `ap_done`; 0 disables timeout
- `CNT_W`, 16, width of completed-task counter

Ports:
- `clk` in 1: single clock, all logic rising-edge
- `rst_n` in 1: reset, synchronous, active-low
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`
- `cmd_task` in 3: `{recv, send, conv}` task code
- `cmd_last` in 1: command closes a batch (layer)
- `task_valid` out 1: one-cycle task issue strobe to responder
- `recv_enable` out 1: pulse, coincident with `task_valid`
- `send_enable` out 1: pulse, coincident with `task_valid`
- `conv_start` out 1: pulse, coincident with `task_valid`
- `ap_done` in 1: level from responder, high once issued task completed
- `busy` out 1: high in any state except IDLE
- `batch_done` out 1: one-cycle pulse when a `cmd_last` task completes
- `err_illegal` out 1: one-cycle pulse, illegal code dropped
- `err_timeout` out 1: one-cycle pulse, `ap_done` not seen in time
- `done_cnt` out CNT_W: tasks completed since reset, wraps

## Operation
- States: IDLE, ISSUE, GUARD, WAIT, DONE.
- IDLE: `cmd_ready`=1. On handshake latch `cmd_task`, `cmd_last`. Legal codes 3'b100, 3'b010, 3'b001, 3'b101 -> ISSUE. Codes 000/011/110/111: command consumed, `err_illegal` pulsed next cycle, stay IDLE.
- ISSUE (1 cycle): `task_valid`=1, enables = latched code bits; load guard counter with GUARD_CYC-1 -> GUARD.
- GUARD: `ap_done` ignored; counter reaches 0 -> WAIT; timeout counter cleared.
- WAIT: `ap_done`=1 -> DONE. Timeout counter increments each cycle; reaching TIMEOUT_CYC-1 without `ap_done` -> `err_timeout` pulse, back to IDLE, `done_cnt` not incremented, no `batch_done`.
- DONE (1 cycle): `done_cnt`+1 (mod 2^CNT_W); `batch_done`=1 if latched last -> IDLE.
- `ap_done` and timeout expiry in same WAIT cycle: `ap_done` wins.
- All enables and `task_valid` are zero outside ISSUE; never two `task_valid` without an intervening DONE or timeout.

## Timing
- Reset values: `cmd_ready`=0 during reset, 1 first cycle after (IDLE); all other outputs 0, `done_cnt`=0, state IDLE.
- Outputs registered. Handshake in cycle A -> `task_valid` high in A+1 -> GUARD A+2..A+1+GUARD_CYC -> `ap_done` first sampled at A+2+GUARD_CYC.
- `ap_done` sampled high in cycle W -> DONE in W+1 (`batch_done` high W+1, `done_cnt` new value visible W+2) -> IDLE/`cmd_ready` W+2.
- Illegal code in A -> `err_illegal` high A+1, `cmd_ready` high A+1.
- Timeout at WAIT cycle count TIMEOUT_CYC -> `err_timeout` high and IDLE next cycle.
- `rst_n` low mid-task: next edge forces IDLE, clears counters/pulses; issued task is abandoned (responder is reset on same net).

## Structure
- Shared package: state enum, legal task-code constants (TASK_RECV, TASK_SEND, TASK_CONV, TASK_RECV_CONV).
- Single module; no sub-module needed (guard and timeout counters inline).

## Test plan
- Single conv (3'b001), responder model raises `ap_done` 10 cycles after `task_valid` -> one `task_valid`+`conv_start` pulse, `done_cnt`=1, no errors.
- Back-to-back recv, send, recv+conv (last on third), stale `ap_done` held high into GUARD -> stale done ignored, exactly 3 issues, `batch_done` once after third, `done_cnt`=3.
- Code 3'b110 then 3'b010 -> `err_illegal` one pulse, no issue for 110, send issued normally.
- TIMEOUT_CYC=16, responder never completes -> `err_timeout` after 16 WAIT cycles, `done_cnt` unchanged, `cmd_ready` high next cycle.
- `rst_n` low in WAIT -> all outputs 0, `done_cnt`=0; next command issues cleanly.
- `done_cnt` preloaded by running 2^CNT_W tasks (CNT_W=4, 16 tasks) -> wraps to 0.

Source files
------------

// File: rtl/task_issuer_pkg.sv
// Shared definitions for the task issuer: FSM state encoding and the legal
// task codes ({recv, send, conv}).
package task_issuer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_GUARD = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [2:0] TASK_RECV      = 3'b100;
    localparam logic [2:0] TASK_SEND      = 3'b010;
    localparam logic [2:0] TASK_CONV      = 3'b001;
    localparam logic [2:0] TASK_RECV_CONV = 3'b101;

    function automatic logic task_legal(input logic [2:0] code);
        return (code == TASK_RECV) || (code == TASK_SEND) ||
               (code == TASK_CONV) || (code == TASK_RECV_CONV);
    endfunction

endpackage

// File: rtl/task_issuer.sv
// Initiator side of the task-control handshake: issues one task at a time,
// waits for ap_done (with a stale-done guard window and a timeout).
module task_issuer
    import task_issuer_pkg::*;
#(
    parameter int GUARD_CYC   = 3,
    parameter int TIMEOUT_CYC = 1048576,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_task,
    input  logic             cmd_last,
    output logic             task_valid,
    output logic             recv_enable,
    output logic             send_enable,
    output logic             conv_start,
    input  logic             ap_done,
    output logic             busy,
    output logic             batch_done,
    output logic             err_illegal,
    output logic             err_timeout,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_e           state_q;
    logic             cmd_ready_q;
    logic             task_valid_q;
    logic             recv_enable_q;
    logic             send_enable_q;
    logic             conv_start_q;
    logic             busy_q;
    logic             batch_done_q;
    logic             err_illegal_q;
    logic             err_timeout_q;
    logic             last_q;
    logic [3:0]       guard_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [CNT_W-1:0] done_cnt_q;
    logic [CNT_W-1:0] done_cnt_d;
    logic             to_expired;

    always_comb begin
        done_cnt_d = done_cnt_q + 1'b1;
        to_expired = (TIMEOUT_CYC != 0) && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            task_valid_q  <= 1'b0;
            recv_enable_q <= 1'b0;
            send_enable_q <= 1'b0;
            conv_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            batch_done_q  <= 1'b0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
            last_q        <= 1'b0;
            guard_cnt_q   <= '0;
            to_cnt_q      <= '0;
            done_cnt_q    <= '0;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            task_valid_q  <= 1'b0;
            recv_enable_q <= 1'b0;
            send_enable_q <= 1'b0;
            conv_start_q  <= 1'b0;
            batch_done_q  <= 1'b0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        last_q <= cmd_last;
                        if (task_legal(cmd_task)) begin
                            state_q       <= ST_ISSUE;
                            cmd_ready_q   <= 1'b0;
                            busy_q        <= 1'b1;
                            task_valid_q  <= 1'b1;
                            recv_enable_q <= cmd_task[2];
                            send_enable_q <= cmd_task[1];
                            conv_start_q  <= cmd_task[0];
                        end else begin
                            err_illegal_q <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q     <= ST_GUARD;
                    guard_cnt_q <= 4'(GUARD_CYC - 1);
                end
                ST_GUARD: begin
                    // ap_done may still show the previous task's completion here.
                    if (guard_cnt_q == '0) begin
                        state_q  <= ST_WAIT;
                        to_cnt_q <= '0;
                    end else begin
                        guard_cnt_q <= guard_cnt_q - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (ap_done) begin
                        state_q      <= ST_DONE;
                        batch_done_q <= last_q;
                    end else if (to_expired) begin
                        state_q       <= ST_IDLE;
                        err_timeout_q <= 1'b1;
                        cmd_ready_q   <= 1'b1;
                        busy_q        <= 1'b0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    done_cnt_q  <= done_cnt_d;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign task_valid  = task_valid_q;
    assign recv_enable = recv_enable_q;
    assign send_enable = send_enable_q;
    assign conv_start  = conv_start_q;
    assign busy        = busy_q;
    assign batch_done  = batch_done_q;
    assign err_illegal = err_illegal_q;
    assign err_timeout = err_timeout_q;
    assign done_cnt    = done_cnt_q;

endmodule

// File: tb/tb_task_issuer.sv
// Bench for task_issuer: cycle-accurate vector table plus directed sequences
// for guard/stale-done, timeout, mid-task reset and counter wrap.
module tb_task_issuer;
    import task_issuer_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_task;
    logic       cmd_last;
    logic       task_valid;
    logic       recv_enable;
    logic       send_enable;
    logic       conv_start;
    logic       ap_done;
    logic       busy;
    logic       batch_done;
    logic       err_illegal;
    logic       err_timeout;
    logic [3:0] done_cnt;

    task_issuer #(
        .GUARD_CYC  (3),
        .TIMEOUT_CYC(16),
        .CNT_W      (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_task   (cmd_task),
        .cmd_last   (cmd_last),
        .task_valid (task_valid),
        .recv_enable(recv_enable),
        .send_enable(send_enable),
        .conv_start (conv_start),
        .ap_done    (ap_done),
        .busy       (busy),
        .batch_done (batch_done),
        .err_illegal(err_illegal),
        .err_timeout(err_timeout),
        .done_cnt   (done_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {cmd_ready, task_valid, recv, send, conv, busy, batch_done, err_illegal, err_timeout}
    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [2:0] code;
        logic       last;
        logic       ap;
        logic [8:0] exp_out;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   tv_cnt = 0;
    int   batch_cnt = 0;
    logic [3:0] exp_cnt = '0;

    always @(posedge clk) begin
        if (task_valid) tv_cnt <= tv_cnt + 1;
        if (batch_done) batch_cnt <= batch_cnt + 1;
    end

    function automatic logic [8:0] outs();
        return {cmd_ready, task_valid, recv_enable, send_enable, conv_start,
                busy, batch_done, err_illegal, err_timeout};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [2:0] c, input logic l,
                       input logic a, input logic [8:0] eo, input logic [3:0] ec);
        vec_t t;
        t.rst_n = r; t.valid = v; t.code = c; t.last = l; t.ap = a;
        t.exp_out = eo; t.exp_cnt = ec;
        vecs.push_back(t);
    endtask

    task automatic send_cmd(input logic [2:0] code, input logic last, output logic ok);
        int n;
        ok = 1'b0;
        n = 0;
        cmd_valid = 1'b1;
        cmd_task  = code;
        cmd_last  = last;
        while (!ok && n < 50) begin
            if (cmd_ready) ok = 1'b1;
            step();
            n++;
        end
        cmd_valid = 1'b0;
        if (!ok) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_task(input logic [2:0] code, input logic last, input logic stale,
                            input int delay);
        logic ok;
        int   n;
        ap_done = stale;
        send_cmd(code, last, ok);
        if (ok) begin
            check("issue", {task_valid, recv_enable, send_enable, conv_start}, {1'b1, code});
            repeat (4) step();
            check("stale_ignored", busy, 1'b1);
            ap_done = 1'b0;
            repeat (delay) step();
            ap_done = 1'b1;
            n = 0;
            while (busy && n < 20) begin
                step();
                n++;
            end
            ap_done = 1'b0;
            check("complete", busy, 1'b0);
            exp_cnt = exp_cnt + 1'b1;
            check("done_cnt", done_cnt, exp_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   tv0, b0;
        logic ok;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_task = '0; cmd_last = 1'b0; ap_done = 1'b0;

        // Reset, single conv completed 10 cycles after issue, then illegal 110 and a send.
        add(0, 0, 3'b000, 0, 0, 9'b000000000, 4'd0);
        add(0, 0, 3'b000, 0, 0, 9'b000000000, 4'd0);
        add(1, 0, 3'b000, 0, 0, 9'b100000000, 4'd0);
        add(1, 1, 3'b001, 0, 0, 9'b010011000, 4'd0);
        for (int i = 0; i < 10; i++) add(1, 0, 3'b001, 0, 0, 9'b000001000, 4'd0);
        add(1, 0, 3'b001, 0, 1, 9'b000001000, 4'd0);
        add(1, 0, 3'b001, 0, 1, 9'b100000000, 4'd1);
        add(1, 0, 3'b001, 0, 0, 9'b100000000, 4'd1);
        add(1, 1, 3'b110, 0, 0, 9'b100000010, 4'd1);
        add(1, 1, 3'b010, 1, 0, 9'b010101000, 4'd1);
        for (int i = 0; i < 4; i++) add(1, 0, 3'b010, 0, 0, 9'b000001000, 4'd1);
        add(1, 0, 3'b010, 0, 1, 9'b000001100, 4'd1);
        add(1, 0, 3'b010, 0, 0, 9'b100000000, 4'd2);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n; cmd_valid = vecs[i].valid; cmd_task = vecs[i].code;
            cmd_last = vecs[i].last; ap_done = vecs[i].ap;
            step();
            check($sformatf("vec%0d", i), {outs(), done_cnt},
                  {vecs[i].exp_out, vecs[i].exp_cnt});
        end
        cmd_valid = 1'b0;
        exp_cnt = 4'd2;

        // Back-to-back recv, send, recv+conv with stale ap_done into the guard window.
        tv0 = tv_cnt; b0 = batch_cnt;
        run_task(TASK_RECV, 1'b0, 1'b1, 2);
        run_task(TASK_SEND, 1'b0, 1'b1, 0);
        run_task(TASK_RECV_CONV, 1'b1, 1'b1, 3);
        check("b2b_issues", tv_cnt - tv0, 3);
        check("b2b_batch", batch_cnt - b0, 1);

        // Responder never answers: timeout after 16 WAIT cycles.
        ap_done = 1'b0;
        send_cmd(TASK_CONV, 1'b0, ok);
        repeat (19) step();
        check("pre_timeout", {err_timeout, busy}, 2'b01);
        step();
        check("timeout", {err_timeout, cmd_ready, busy}, 3'b110);
        check("timeout_cnt", done_cnt, exp_cnt);
        step();
        check("timeout_pulse", err_timeout, 1'b0);

        // Reset while waiting for completion.
        send_cmd(TASK_RECV, 1'b0, ok);
        repeat (6) step();
        check("in_wait", busy, 1'b1);
        rst_n = 1'b0;
        step();
        check("reset_mid", {outs(), done_cnt}, 13'd0);
        rst_n = 1'b1;
        step();
        check("post_reset", outs(), 9'b100000000);
        exp_cnt = '0;
        run_task(TASK_CONV, 1'b0, 1'b0, 2);

        // Fifteen more completions wrap the 4-bit counter back to zero.
        for (int i = 0; i < 15; i++) run_task(TASK_RECV_CONV, (i == 14), 1'b0, 1);
        check("wrap", done_cnt, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
